// File: rtl/sram_like_resp.sv
// rtl/sram_like_resp.sv - wait-state SRAM-like responder with stall/hold handshake
//
// Purpose: single-port 32-bit word memory that answers CPU requests after a
// fixed number of wait states. It raises stall while an access is pending,
// then parks in DONE until the CPU pipeline releases hold.
//
// Ports:
//   clk   - single clock, rising edge
//   rst   - asynchronous active-low reset
//   en    - request valid, held stable by the CPU while stall or hold is high
//   wen   - byte write enables; 4'b0000 selects a read
//   addr  - byte address; word index is addr[ADDR_W+1:2]
//   wdata - write data
//   hold  - CPU has not yet consumed the completed response
//   rdata - registered read data
//   stall - access outstanding
module sram_like_resp #(
  parameter int ADDR_W = 10,
  parameter int WAIT   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [3:0]  wen,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        hold,
  output logic [31:0] rdata,
  output logic        stall
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic [3:0]        wen_q;
  logic [ADDR_W-1:0] idx_q;
  logic [31:0]       wdata_q;
  logic [31:0]       mem [2**ADDR_W];
  logic              fire;
  logic              unused_addr;

  // Address bits outside the word index are deliberately ignored.
  assign unused_addr = ^{addr[31:ADDR_W+2], addr[1:0]};

  // Stall is combinational so the CPU freezes in the very cycle it asks;
  // dropping en while BUSY releases stall immediately (abort).
  assign stall = en && ((state == IDLE) || (state == BUSY));

  // The access happens on the last wait-state edge, and only if the request
  // is still present; an abort on that same cycle wins.
  assign fire = (state == BUSY) && en && (cnt == 4'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      rdata   <= 32'h0;
      wen_q   <= 4'd0;
      idx_q   <= '0;
      wdata_q <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            wen_q   <= wen;
            idx_q   <= addr[ADDR_W+1:2];
            wdata_q <= wdata;
            cnt     <= 4'(WAIT);
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (!en) begin
            state <= IDLE;
          end else if (cnt == 4'd1) begin
            if (wen_q == 4'd0) begin
              rdata <= mem[idx_q];
            end
            state <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          // The access already happened on entry; holding here never repeats it.
          if (!hold) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory array is never reset. The rst term keeps a write from landing on
  // an edge where reset is asserted.
  always_ff @(posedge clk) begin
    if (rst && fire) begin
      for (int i = 0; i < 4; i++) begin
        if (wen_q[i]) begin
          mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

endmodule
